vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receiving end of the VGA timing interface: consumes the hor_sync/ver_sync/red/green/blue stream produced by the display pipeline, sampled on the pixel-enable strobe.
- Recovers column/row coordinates, checks the timing against nominal 640x480 parameters, and reports lock.
- Used as an on-chip frame checker and in the game-level bench to turn the VGA output back into pixel coordinates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low
- LOCK_FRAMES, 2, consecutive clean frames required for lock (1..15)

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- pix_en  input  1  one-cycle pixel strobe (the vga_clk enable); samples are taken only when high
- hor_sync  input  1  horizontal sync
- ver_sync  input  1  vertical sync
- red, green, blue  input  8 each  pixel colour
- pixel_valid  output  1  one-cycle strobe: decoded active pixel
- column  output  10  x of the decoded pixel, 0..H_ACTIVE-1
- row  output  10  y of the decoded pixel, 0..V_ACTIVE-1
- red_out, green_out, blue_out  output  8 each  captured colour
- frame_start  output  1  pulses together with pixel_valid at column 0, row 0
- locked  output  1  timing locked
- h_err  output  1  one-cycle pulse: horizontal timing violation
- v_err  output  1  one-cycle pulse: vertical timing violation
- err_count  output  16  saturating violation counter

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSM goes to SEARCH; counters 0.
  - Previous-sync registers inactive.
- Sampling and sync polarity:
  - Sample only on cycles with pix_en=1. With pix_en=0, all state is frozen and the pulse outputs are 0.
  - hs_act = hor_sync XOR SYNC_ACTIVE_LOW; vs_act likewise.
- Horizontal timing (H_TOTAL = sum of the H parameters):
  - h_cnt is 11 bits. It is cleared on an hs_act rising sample; otherwise it increments, saturating at 2047.
  - On the hs_act rise, if h_cnt+1 != H_TOTAL, flag h_err.
  - On the hs_act fall, if h_cnt+1 != H_SYNC, flag h_err.
- Vertical timing (V_TOTAL = sum of the V parameters):
  - v_cnt is 11 bits and updates only at hs_act rise (line boundary). vs_act is sampled at each line boundary.
  - On a vs_act rise between lines, v_cnt is cleared and a frame end is declared. If the previous v_cnt+1 != V_TOTAL, flag v_err.
  - On a vs_act fall, if v_cnt+1 != V_SYNC, flag v_err.
  - Otherwise v_cnt increments, saturating at 2047.
- Active window:
  - Horizontal: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1]; column = h_cnt-(H_SYNC+H_BACK).
  - Vertical: v_cnt in [V_SYNC+V_BACK, ...+V_ACTIVE-1]; row analogous.
- Output latency:
  - Outputs register on the cycle after the pix_en sample.
  - pixel_valid=1 only when locked=1 (as of the sample) and inside the active window.
  - column, row and the captured colour hold their last value otherwise.
- FSM:
  - SEARCH → TRACK at the first vs_act rise; good=0. h_err/v_err are suppressed in SEARCH.
  - TRACK:
    - Any flag clears good.
    - An error-free frame end increments good.
    - good == LOCK_FRAMES → LOCKED.
  - LOCKED → TRACK (good=0) on any flag; locked falls on the following cycle.
  - locked = (state == LOCKED).
- Error pulses and counter:
  - h_err and v_err register in the same cycle as the outputs.
  - err_count adds h_err+v_err, so simultaneous errors add 2. It saturates at 65535 and clears only on reset.
  - A frame end that coincides with an error is not counted as clean.

Test Plan:
- Clean 640x480 stream, pix_en every 2nd clk, sync begins mid-frame → no h_err/v_err; locked rises at the 2nd frame end after the first vsync; each locked frame then gives exactly 307200 pixel_valid strobes; frame_start occurs once per frame with column=0, row=0.
- Colour pattern red=column[7:0], green=row[7:0] → every pixel_valid has red_out==column[7:0] and green_out==row[7:0]; the last pixel is column 639, row 479.
- One line shortened to 799 pixels in a locked stream → exactly one h_err, err_count=1, locked drops, pixel_valid stops; locked returns 2 clean frames later.
- Vsync held 3 lines → one v_err at vsync fall; frame-length check also fails next frame (v_err, err_count=2); relock follows.
- rst_n pulsed low mid-frame → all outputs 0 immediately (asynchronous); no pixel_valid until the first vsync plus LOCK_FRAMES clean frames.
- pix_en held 0 for 1000 clk while syncs toggle → counters, FSM and outputs unchanged; behaviour resumes at the exact count when pix_en returns.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from a VGA sync/colour
// stream, checks line/frame timing and reports lock.
// Ports: clk, rst_n (async, active low), pix_en (sample strobe),
//   hor_sync/ver_sync/red/green/blue (VGA stream in),
//   pixel_valid/column/row/red_out/green_out/blue_out (decoded pixel),
//   frame_start, locked, h_err/v_err (violation pulses), err_count.
module vga_sync_decoder #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hor_sync,
  input  logic        ver_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  column,
  output logic [9:0]  row,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] H_SW  = 12'(H_SYNC);
  localparam logic [11:0] V_TOT = 12'(V_TOTAL);
  localparam logic [11:0] V_SW  = 12'(V_SYNC);
  localparam logic [10:0] H_LO  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_HI  = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [3:0]  LOCK  = 4'(LOCK_FRAMES);
  localparam logic        POL   = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hs_prev_q, vs_prev_q;
  logic        pv_q, pv_d;
  logic        fs_q, fs_d;
  logic        herr_q, herr_d;
  logic        verr_q, verr_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [7:0]  r_q, g_q, b_q;
  logic [15:0] ec_q, ec_d;
  logic [16:0] ec_sum;

  logic hs_act, vs_act;
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic h_flag, v_flag, flag, in_win;

  always_comb begin
    hs_act  = hor_sync ^ POL;
    vs_act  = ver_sync ^ POL;
    hs_rise = hs_act & ~hs_prev_q;
    hs_fall = ~hs_act & hs_prev_q;
    // vsync is only looked at on line boundaries
    vs_rise = hs_rise & vs_act & ~vs_prev_q;
    vs_fall = hs_rise & ~vs_act & vs_prev_q;

    h_cnt_d = (h_cnt_q == 11'h7ff) ? h_cnt_q : h_cnt_q + 11'd1;
    if (hs_rise) h_cnt_d = '0;

    v_cnt_d = v_cnt_q;
    if (hs_rise) begin
      v_cnt_d = (v_cnt_q == 11'h7ff) ? v_cnt_q : v_cnt_q + 11'd1;
      if (vs_rise) v_cnt_d = '0;
    end

    h_flag = (hs_rise && ({1'b0, h_cnt_q} + 12'd1) != H_TOT)
          || (hs_fall && ({1'b0, h_cnt_q} + 12'd1) != H_SW);
    v_flag = (vs_rise && ({1'b0, v_cnt_q} + 12'd1) != V_TOT)
          || (vs_fall && ({1'b0, v_cnt_q} + 12'd1) != V_SW);
    flag   = h_flag | v_flag;

    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (flag) begin
          good_d = '0;
        end else if (vs_rise) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LOCK) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (flag) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    // window uses the count of the pixel being sampled now
    in_win = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI)
          && (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
    pv_d   = pix_en & (state_q == LOCKED) & in_win;
    col_d  = pv_d ? 10'(h_cnt_d - H_LO) : col_q;
    row_d  = pv_d ? 10'(v_cnt_d - V_LO) : row_q;
    fs_d   = pv_d && (col_d == '0) && (row_d == '0);

    herr_d = pix_en & h_flag & (state_q != SEARCH);
    verr_d = pix_en & v_flag & (state_q != SEARCH);
    ec_sum = {1'b0, ec_q} + 17'(herr_d) + 17'(verr_d);
    ec_d   = ec_sum[16] ? 16'hffff : ec_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      pv_q      <= 1'b0;
      fs_q      <= 1'b0;
      herr_q    <= 1'b0;
      verr_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      ec_q      <= '0;
    end else begin
      pv_q   <= pv_d;
      fs_q   <= fs_d;
      herr_q <= herr_d;
      verr_q <= verr_d;
      ec_q   <= ec_d;
      col_q  <= col_d;
      row_q  <= row_d;
      if (pv_d) begin
        r_q <= red;
        g_q <= green;
        b_q <= blue;
      end
      if (pix_en) begin
        state_q   <= state_d;
        good_q    <= good_d;
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        hs_prev_q <= hs_act;
        if (hs_rise) vs_prev_q <= vs_act;
      end
    end
  end

  assign pixel_valid = pv_q;
  assign frame_start = fs_q;
  assign column      = col_q;
  assign row         = row_q;
  assign red_out     = r_q;
  assign green_out   = g_q;
  assign blue_out    = b_q;
  assign locked      = (state_q == LOCKED);
  assign h_err       = herr_q;
  assign v_err       = verr_q;
  assign err_count   = ec_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed stream on a shrunken 4x3 raster
// (8 clocks/line, 7 lines/frame) with a queue-based scoreboard.
module tb_vga_sync_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        hor_sync = 1'b1;
  logic        ver_sync = 1'b1;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        pixel_valid, frame_start, locked, h_err, v_err;
  logic [9:0]  column, row;
  logic [7:0]  red_out, green_out, blue_out;
  logic [15:0] err_count;

  vga_sync_decoder #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hor_sync(hor_sync), .ver_sync(ver_sync),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .column(column), .row(row),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] c;
    logic [9:0] r;
    logic [7:0] b;
    logic       fs;
  } px_t;

  px_t        pxq[$];
  logic [1:0] errq[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_pix = 0;
  int p0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pixel_valid) begin
      n_pix++;
      if (pxq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_pixel: got col %0d row %0d expected none",
                 column, row);
      end else begin
        px_t e;
        e = pxq.pop_front();
        chk("column", 32'(column), 32'(e.c));
        chk("row", 32'(row), 32'(e.r));
        chk("red_out", 32'(red_out), 32'(e.c[7:0]));
        chk("green_out", 32'(green_out), 32'(e.r[7:0]));
        chk("blue_out", 32'(blue_out), 32'(e.b));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end else if (frame_start) begin
      chk("frame_start_alone", 32'(frame_start), 32'd0);
    end
    if (h_err || v_err) begin
      if (errq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_err: got h %0d v %0d expected none",
                 h_err, v_err);
      end else begin
        chk("err_pulse", 32'({h_err, v_err}), 32'(errq.pop_front()));
      end
    end
  end

  // one sample: x<2 is hsync, x 3..6 / lines 3..5 are visible
  task automatic pix(int ln, int x, bit vs, bit lk);
    logic [9:0] c, r;
    logic [7:0] b;
    bit act;
    @(negedge clk);
    act = (x >= 3) && (x <= 6) && (ln >= 3) && (ln <= 5);
    c = act ? 10'(x - 3) : 10'h3ff;
    r = act ? 10'(ln - 3) : 10'h3ff;
    b = 8'(x * 16 + ln + 8'h40);
    hor_sync = !(x < 2);
    ver_sync = !vs;
    red      = c[7:0];
    green    = r[7:0];
    blue     = b;
    pix_en   = 1'b1;
    if (lk && act) pxq.push_back('{c, r, b, (c == 0) && (r == 0)});
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic line(int ln, int x0, int x1, bit lk);
    for (int x = x0; x <= x1; x++) pix(ln, x, ln < 2, lk);
  endtask

  task automatic frame(int l0, int l1, bit lk);
    for (int ln = l0; ln <= l1; ln++) line(ln, 0, 7, lk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pv", 32'(pixel_valid), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_column", 32'(column), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_herr", 32'(h_err), 0);
    rst_n = 1'b1;

    // stream picked up mid-frame
    frame(4, 6, 0);
    frame(0, 6, 0);
    frame(0, 6, 0);
    chk("lock_pre", 32'(locked), 0);
    p0 = n_pix;
    line(0, 0, 0, 1);
    chk("lock_rise", 32'(locked), 1);
    line(0, 1, 7, 1);
    frame(1, 6, 1);
    chk("f3_pix", 32'(n_pix - p0), 12);
    p0 = n_pix;
    frame(0, 6, 1);
    chk("f4_pix", 32'(n_pix - p0), 12);
    chk("f4_errcnt", 32'(err_count), 0);

    // short line 3 (7 pixels)
    p0 = n_pix;
    frame(0, 2, 1);
    line(3, 0, 6, 1);
    errq.push_back(2'b10);
    line(4, 0, 0, 0);
    chk("lock_drop_h", 32'(locked), 0);
    line(4, 1, 7, 0);
    frame(5, 6, 0);
    chk("short_pix", 32'(n_pix - p0), 4);
    chk("short_errcnt", 32'(err_count), 1);
    frame(0, 6, 0);
    chk("relock1_wait", 32'(locked), 0);
    p0 = n_pix;
    line(0, 0, 7, 1);
    chk("relock1", 32'(locked), 1);
    frame(1, 6, 1);
    chk("f7_pix", 32'(n_pix - p0), 12);

    // vsync held three lines -> 8-line frame
    p0 = n_pix;
    for (int ln = 0; ln < 8; ln++)
      for (int x = 0; x < 8; x++) begin
        if (ln == 3 && x == 0) errq.push_back(2'b01);
        pix(ln, x, ln < 3, 0);
      end
    chk("lock_drop_v", 32'(locked), 0);
    chk("vs_errcnt", 32'(err_count), 2);
    chk("vs_pix", 32'(n_pix - p0), 0);
    errq.push_back(2'b01);
    frame(0, 6, 0);
    chk("len_errcnt", 32'(err_count), 3);
    frame(0, 6, 0);
    chk("relock2_wait", 32'(locked), 0);
    line(0, 0, 7, 1);
    chk("relock2", 32'(locked), 1);
    frame(1, 3, 1);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_errcnt", 32'(err_count), 0);
    chk("arst_column", 32'(column), 0);
    chk("arst_red", 32'(red_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pix;
    frame(4, 6, 0);
    frame(0, 6, 0);
    frame(0, 6, 0);
    chk("post_rst_wait", 32'(locked), 0);
    chk("post_rst_pix", 32'(n_pix - p0), 0);
    p0 = n_pix;
    line(0, 0, 7, 1);
    chk("post_rst_lock", 32'(locked), 1);
    frame(1, 2, 1);
    line(3, 0, 4, 1);

    // pix_en held low while syncs wiggle
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      hor_sync = 1'($urandom);
      ver_sync = 1'($urandom);
      red      = 8'($urandom);
      if (i % 50 == 0) begin
        chk("frz_pv", 32'(pixel_valid), 0);
        chk("frz_err", 32'({h_err, v_err}), 0);
        chk("frz_col", 32'(column), 1);
        chk("frz_row", 32'(row), 0);
        chk("frz_lock", 32'(locked), 1);
      end
    end
    line(3, 5, 7, 1);
    frame(4, 6, 1);
    chk("f14_pix", 32'(n_pix - p0), 12);
    chk("f14_errcnt", 32'(err_count), 0);
    p0 = n_pix;
    frame(0, 6, 1);
    chk("f15_pix", 32'(n_pix - p0), 12);
    chk("f15_last_col", 32'(column), 3);
    chk("f15_last_row", 32'(row), 2);
    chk("f15_lock", 32'(locked), 1);

    repeat (4) @(negedge clk);
    chk("px_left", 32'(pxq.size()), 0);
    chk("err_left", 32'(errq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
